// File: rtl/demux1_8_16b_buf.sv
// ============================================================================
// demux1_8_16b_buf
// ----------------------------------------------------------------------------
// Buffered 1-to-8 demultiplexer for 16-bit operands. A single producer stream
// carrying a 3-bit destination select is steered into one of eight per-lane
// FIFOs. Each lane drains through its own valid/ready consumer handshake.
//
// Ports
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         producer presents in_data/in_sel
//   in_ready   out  1         selected lane can accept this cycle
//   in_data    in   W         operand to deliver
//   in_sel     in   3         destination lane 0..7
//   in_bcast   in   1         (DEMUX_BCAST_EN only) push into all 8 lanes
//   out_valid  out  8         lane i head entry valid
//   out_ready  in   8         consumer i takes head this cycle
//   out_data   out  8*W       lane i at [W*i +: W]; zero when lane is empty
//   lane_full  out  8         lane i holds LANE_DEPTH entries
//
// Configuration
//   DEMUX_BCAST_EN  when defined, adds in_bcast. A broadcast is accepted only
//                   when every lane can take a word, so lanes are never
//                   partially written.
// ============================================================================
module demux1_8_16b_buf #(
    parameter int OPERAND_WIDTH = 16,
    parameter int LANE_DEPTH    = 2,
    parameter int LANE_PTR_W    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPERAND_WIDTH-1:0]   in_data,
    input  logic [2:0]                 in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic                       in_bcast,
`endif
    output logic [7:0]                 out_valid,
    input  logic [7:0]                 out_ready,
    output logic [8*OPERAND_WIDTH-1:0] out_data,
    output logic [7:0]                 lane_full
);

    localparam logic [LANE_PTR_W:0]   DEPTH_C = (LANE_PTR_W+1)'(LANE_DEPTH);
    localparam logic [LANE_PTR_W:0]   ONE_C   = (LANE_PTR_W+1)'(1);
    localparam logic [LANE_PTR_W-1:0] ONE_P   = LANE_PTR_W'(1);

    logic [7:0] lane_accept;
    logic [7:0] push;
    logic [7:0] pop;
    logic       bcast_sel;

`ifdef DEMUX_BCAST_EN
    assign bcast_sel = in_valid & in_bcast;
`else
    assign bcast_sel = 1'b0;
`endif

    // A full lane still accepts when its consumer drains the head in the
    // same cycle; the write lands in the slot being vacated.
    assign in_ready = bcast_sel ? (&lane_accept) : lane_accept[in_sel];

    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [LANE_PTR_W-1:0]    wr_ptr;
        logic [LANE_PTR_W-1:0]    rd_ptr;
        logic [LANE_PTR_W:0]      count;
        logic [OPERAND_WIDTH-1:0] mem [LANE_DEPTH];

        assign out_valid[i]   = (count != '0);
        assign lane_full[i]   = (count == DEPTH_C);
        assign lane_accept[i] = (count < DEPTH_C) | (out_ready[i] & lane_full[i]);
        assign pop[i]         = out_valid[i] & out_ready[i];
        assign push[i]        = in_valid & in_ready & (bcast_sel | (in_sel == 3'(i)));

        // Head is masked to zero when empty so stale storage never leaks out.
        assign out_data[OPERAND_WIDTH*i +: OPERAND_WIDTH] =
            out_valid[i] ? mem[rd_ptr] : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[i]) wr_ptr <= wr_ptr + ONE_P;
                if (pop[i])  rd_ptr <= rd_ptr + ONE_P;
                case ({push[i], pop[i]})
                    2'b10:   count <= count + ONE_C;
                    2'b01:   count <= count - ONE_C;
                    default: count <= count;
                endcase
            end
        end

        // Storage is not reset; count gates visibility of every entry.
        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_demux1_8_16b_buf.sv
module tb_demux1_8_16b_buf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_bcast;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [127:0] out_data;
    logic [7:0]   lane_full;

    int errors = 0;
    int checks = 0;

    // Scoreboard: one expected-data queue per lane.
    logic [15:0] sb [8][$];
    int delivered7;

    demux1_8_16b_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .lane_full (lane_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_accept(input int lane);
        int c;
        c = sb[lane].size();
        return (c < 2) || (out_ready[lane] && c == 2);
    endfunction

    function automatic bit model_bcast();
`ifdef DEMUX_BCAST_EN
        return in_valid && in_bcast;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        bit r;
        if (model_bcast()) begin
            r = 1'b1;
            for (int i = 0; i < 8; i++) r &= model_accept(i);
        end else begin
            r = model_accept(int'(in_sel));
        end
        return r;
    endfunction

    // Called just after inputs are driven (at the falling edge). Compares
    // all outputs against the model, then advances the model across the
    // next rising edge.
    task automatic cycle();
        bit          exp_rdy;
        bit [7:0]    do_push;
        bit [7:0]    do_pop;
        logic [15:0] head;
        #1;
        exp_rdy = model_ready();
        for (int i = 0; i < 8; i++) begin
            head = (sb[i].size() != 0) ? sb[i][0] : 16'h0000;
            chk($sformatf("valid[%0d]", i), 128'(out_valid[i]), 128'(sb[i].size() != 0));
            chk($sformatf("data[%0d]", i), 128'(out_data[16*i +: 16]), 128'(head));
            chk($sformatf("full[%0d]", i), 128'(lane_full[i]), 128'(sb[i].size() == 2));
            do_pop[i]  = out_ready[i] && (sb[i].size() != 0);
            do_push[i] = in_valid && exp_rdy && (model_bcast() || in_sel == 3'(i));
        end
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (do_pop[i]) begin
                void'(sb[i].pop_front());
                if (i == 7) delivered7++;
            end
            if (do_push[i]) sb[i].push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        out_ready = 8'h00;
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        in_valid  = 1'b0;
        out_ready = 8'hFF;
        while (guard < 20) begin
            bit empty;
            empty = 1'b1;
            for (int i = 0; i < 8; i++) if (sb[i].size() != 0) empty = 1'b0;
            if (empty) break;
            cycle();
            guard++;
        end
        chk("drain_bound", 128'(guard < 20), 128'(1));
        out_ready = 8'h00;
    endtask

    initial begin
        int guard;
        logic [15:0] word;

        rst_n = 1'b0;
        idle();
        in_data = 16'h0000;
        in_sel  = 3'd0;
        delivered7 = 0;
        #2;
        chk("rst_valid", 128'(out_valid), 128'(8'h00));
        chk("rst_data", out_data, 128'h0);
        chk("rst_full", 128'(lane_full), 128'(8'h00));
        chk("rst_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Ready on empty lanes ignored.
        out_ready = 8'hFF;
        cycle();
        out_ready = 8'h00;

        // Latency.
        in_valid = 1'b1; in_sel = 3'd5; in_data = 16'hBEEF;
        cycle();
        in_valid = 1'b0;
        #1;
        chk("lat_valid", 128'(out_valid), 128'(8'h20));
        chk("lat_data5", 128'(out_data[80 +: 16]), 128'(16'hBEEF));
        cycle();
        drain_all();

        // Full / backpressure on lane 2.
        in_valid = 1'b1; in_sel = 3'd2;
        in_data = 16'h2001; cycle();
        in_data = 16'h2002; cycle();
        in_data = 16'h2003;
        #1;
        chk("bp_ready_low", 128'(in_ready), 128'(0));
        chk("bp_full2", 128'(lane_full[2]), 128'(1));
        cycle();
        out_ready[2] = 1'b1;
        #1;
        chk("bp_ready_drain", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0; out_ready = 8'h00;
        #1;
        chk("bp_still_full", 128'(lane_full[2]), 128'(1));
        chk("bp_head", 128'(out_data[32 +: 16]), 128'(16'h2002));
        cycle();
        drain_all();

        // Wrap / order on lane 7.
        delivered7 = 0;
        word  = 16'h0001;
        guard = 0;
        in_sel = 3'd7;
        while (word <= 16'h0010 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = word;
            out_ready[7] = guard[0];
            #1;
            if (model_ready()) begin
                cycle();
                word++;
            end else begin
                cycle();
            end
            guard++;
        end
        chk("stream_bound", 128'(guard < 100), 128'(1));
        drain_all();
        chk("stream_count", 128'(delivered7), 128'(16));

        // Independence: lane 0 full and stalled, push to lane 1.
        in_valid = 1'b1; in_sel = 3'd0;
        in_data = 16'hA000; cycle();
        in_data = 16'hA001; cycle();
        in_sel = 3'd1; in_data = 16'hB111;
        #1;
        chk("ind_ready", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0;
        #1;
        chk("ind_valid", 128'(out_valid), 128'(8'h03));
        chk("ind_lane1", 128'(out_data[16 +: 16]), 128'(16'hB111));
        chk("ind_lane0", 128'(out_data[0 +: 16]), 128'(16'hA000));
        cycle();

        // Mid-stream reset with lane 3 holding two words.
        drain_all();
        in_valid = 1'b1; in_sel = 3'd3;
        in_data = 16'h3001; cycle();
        in_data = 16'h3002; cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 128'(out_valid), 128'(8'h00));
        chk("mrst_data", out_data, 128'h0);
        chk("mrst_ready", 128'(in_ready), 128'(1));
        chk("mrst_full", 128'(lane_full), 128'(8'h00));
        for (int i = 0; i < 8; i++) sb[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

`ifdef DEMUX_BCAST_EN
        in_valid = 1'b1; in_sel = 3'd4;
        in_data = 16'h4001; cycle();
        in_data = 16'h4002; cycle();
        in_bcast = 1'b1; in_sel = 3'd0; in_data = 16'h1234;
        #1;
        chk("bc_blocked", 128'(in_ready), 128'(0));
        cycle();
        chk("bc_none_written", 128'(out_valid), 128'(8'h10));
        out_ready[4] = 1'b1;
        #1;
        chk("bc_ready", 128'(in_ready), 128'(1));
        cycle();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 8'h00;
        #1;
        chk("bc_all_valid", 128'(out_valid), 128'(8'hFF));
        chk("bc_lane0", 128'(out_data[0 +: 16]), 128'(16'h1234));
        chk("bc_lane7", 128'(out_data[112 +: 16]), 128'(16'h1234));
        cycle();
        drain_all();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
